// File: rtl/mem_wb_skid_stage_pkg.sv
// Shared definitions for the MEM/WB skid stage.
// Holds the default widths, the payload record carried through the stage,
// the writeback-select encoding, and the packed payload width helper.
package mem_wb_skid_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    // One MEM/WB entry, field order matching the packed payload vector.
    typedef struct packed {
        logic                  regwrite;
        logic                  jump;
        logic                  memtoreg;
        logic [DATA_W_DEF-1:0] aluResult;
        logic [DATA_W_DEF-1:0] memReadData;
        logic [REG_W_DEF-1:0]  regDstMux;
    } wb_payload_t;

    // Writeback-select encoding, driven by the memtoreg bit.
    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

    function automatic int payload_width(input int data_w, input int reg_w);
        return 3 + 2 * data_w + reg_w;
    endfunction

endpackage

// File: rtl/mem_wb_skid_stage_if.sv
// MEM/WB stage bus: MEM-side push handshake, flush, WB-side pop handshake,
// head outputs and occupancy.
//   master : surrounding pipeline (drives in_*, flush, out_ready)
//   slave  : the skid stage (drives in_ready, head outputs, occupancy)
interface mem_wb_skid_stage_if
    import mem_wb_skid_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              regwriteIn;
    logic              jumpIn;
    logic              memtoregIn;
    logic [DATA_W-1:0] aluResultIn;
    logic [DATA_W-1:0] memReadDataIn;
    logic [REG_W-1:0]  regDstMuxIn;
    logic              out_valid;
    logic              out_ready;
    logic              regwrite;
    logic              jump;
    logic              memtoreg;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] memReadData;
    logic [REG_W-1:0]  regDstMux;
    logic [DATA_W-1:0] wbData;
    logic [1:0]        occupancy;

    modport master (
        output flush, in_valid, regwriteIn, jumpIn, memtoregIn,
               aluResultIn, memReadDataIn, regDstMuxIn, out_ready,
        input  in_ready, out_valid, regwrite, jump, memtoreg,
               aluResult, memReadData, regDstMux, wbData, occupancy
    );

    modport slave (
        input  flush, in_valid, regwriteIn, jumpIn, memtoregIn,
               aluResultIn, memReadDataIn, regDstMuxIn, out_ready,
        output in_ready, out_valid, regwrite, jump, memtoreg,
               aluResult, memReadData, regDstMux, wbData, occupancy
    );

endinterface

// File: rtl/mem_wb_skid_stage_skid_reg2.sv
// skid_reg2: generic 2-entry valid/ready skid buffer over an opaque payload.
// Ports: i_clk, i_rst_n (async active-low), i_flush (sync clear),
//        i_valid/o_ready/i_data (push side), o_valid/i_ready/o_data (pop side),
//        o_occupancy (0..2).
// o_ready depends only on flops, so downstream stalls never reach upstream
// combinationally.
module skid_reg2 #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_occupancy
);
    logic             r_h_valid;
    logic [WIDTH-1:0] r_h_data;
    logic             r_s_valid;
    logic [WIDTH-1:0] r_s_data;
    logic             w_push;
    logic             w_pop;

    assign o_ready     = ~r_s_valid;
    assign w_push      = i_valid & ~r_s_valid;
    assign w_pop       = r_h_valid & i_ready;
    assign o_valid     = r_h_valid;
    assign o_data      = r_h_data;
    assign o_occupancy = 2'(r_h_valid) + 2'(r_s_valid);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h_valid <= 1'b0;
            r_h_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
        end else if (i_flush) begin
            r_h_valid <= 1'b0;
            r_h_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
        end else if (!r_h_valid) begin
            // S is never occupied while H is empty, so only H can load here.
            if (w_push) begin
                r_h_valid <= 1'b1;
                r_h_data  <= i_data;
            end
        end else if (w_pop) begin
            if (r_s_valid) begin
                // Skid drains into head; push is blocked since o_ready was 0.
                r_h_data  <= r_s_data;
                r_s_valid <= 1'b0;
            end else if (w_push) begin
                r_h_data  <= i_data;
            end else begin
                r_h_valid <= 1'b0;
            end
        end else if (w_push) begin
            r_s_valid <= 1'b1;
            r_s_data  <= i_data;
        end
    end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: MEM/WB pipeline register with valid/ready handshake and
// 2-entry skid buffer, synchronous flush, valid-gated control outputs,
// optional r0 write suppression and the writeback data mux.
// Ports: clk, startin (async active-low reset), bus (slave side of
//        mem_wb_skid_stage_if carrying both handshakes and the payload).
module mem_wb_skid_stage
    import mem_wb_skid_stage_pkg::*;
#(
    parameter int DATA_W            = DATA_W_DEF,
    parameter int REG_W             = REG_W_DEF,
    parameter int ZERO_REG_SUPPRESS = 1
) (
    input  logic                clk,
    input  logic                startin,
    mem_wb_skid_stage_if.slave  bus
);
    localparam int   PW     = payload_width(DATA_W, REG_W);
    localparam logic ZRS_EN = (ZERO_REG_SUPPRESS != 0);

    logic [PW-1:0]     w_in_data;
    logic [PW-1:0]     w_head;
    logic              w_h_valid;
    logic              w_h_regwrite;
    logic              w_h_jump;
    logic              w_h_memtoreg;
    logic [DATA_W-1:0] w_h_alu;
    logic [DATA_W-1:0] w_h_mem;
    logic [REG_W-1:0]  w_h_dst;

    assign w_in_data = {bus.regwriteIn, bus.jumpIn, bus.memtoregIn,
                        bus.aluResultIn, bus.memReadDataIn, bus.regDstMuxIn};

    skid_reg2 #(.WIDTH(PW)) u_skid (
        .i_clk       (clk),
        .i_rst_n     (startin),
        .i_flush     (bus.flush),
        .i_valid     (bus.in_valid),
        .o_ready     (bus.in_ready),
        .i_data      (w_in_data),
        .o_valid     (w_h_valid),
        .i_ready     (bus.out_ready),
        .o_data      (w_head),
        .o_occupancy (bus.occupancy)
    );

    assign {w_h_regwrite, w_h_jump, w_h_memtoreg, w_h_alu, w_h_mem, w_h_dst} = w_head;

    assign bus.out_valid   = w_h_valid;
    assign bus.jump        = w_h_jump & w_h_valid;
    assign bus.memtoreg    = w_h_memtoreg & w_h_valid;
    assign bus.regwrite    = w_h_regwrite & w_h_valid & ~(ZRS_EN & (w_h_dst == '0));
    assign bus.aluResult   = w_h_alu;
    assign bus.memReadData = w_h_mem;
    assign bus.regDstMux   = w_h_dst;

    // Select uses the raw head bit so wbData tracks the held payload.
    always_comb begin
        bus.wbData = '0;
        case (w_h_memtoreg)
            WB_SEL_MEM: bus.wbData = w_h_mem;
            WB_SEL_ALU: bus.wbData = w_h_alu;
        endcase
    end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Testbench for mem_wb_skid_stage: directed scenarios then random traffic,
// checked every cycle against a queue-based model of a 2-deep in-order
// buffer. A second instance with r0 suppression disabled sees identical
// stimulus.
module tb_mem_wb_skid_stage;
    import mem_wb_skid_stage_pkg::*;

    logic clk = 1'b0;
    logic startin = 1'b0;
    int   total = 0;
    int   bad   = 0;

    wb_payload_t q[$];
    wb_payload_t stale = '0;

    mem_wb_skid_stage_if #(.DATA_W(DATA_W_DEF), .REG_W(REG_W_DEF)) mif ();
    mem_wb_skid_stage_if #(.DATA_W(DATA_W_DEF), .REG_W(REG_W_DEF)) mif0 ();

    assign mif0.flush         = mif.flush;
    assign mif0.in_valid      = mif.in_valid;
    assign mif0.regwriteIn    = mif.regwriteIn;
    assign mif0.jumpIn        = mif.jumpIn;
    assign mif0.memtoregIn    = mif.memtoregIn;
    assign mif0.aluResultIn   = mif.aluResultIn;
    assign mif0.memReadDataIn = mif.memReadDataIn;
    assign mif0.regDstMuxIn   = mif.regDstMuxIn;
    assign mif0.out_ready     = mif.out_ready;

    mem_wb_skid_stage #(.DATA_W(DATA_W_DEF), .REG_W(REG_W_DEF), .ZERO_REG_SUPPRESS(1)) u_dut (
        .clk(clk), .startin(startin), .bus(mif));
    mem_wb_skid_stage #(.DATA_W(DATA_W_DEF), .REG_W(REG_W_DEF), .ZERO_REG_SUPPRESS(0)) u_dut0 (
        .clk(clk), .startin(startin), .bus(mif0));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        wb_payload_t h;
        logic v;
        logic rw_exp;
        v = (q.size() > 0);
        h = v ? q[0] : stale;
        chk("out_valid", 64'(mif.out_valid), 64'(v));
        chk("in_ready", 64'(mif.in_ready), 64'(q.size() < 2));
        chk("occupancy", 64'(mif.occupancy), 64'(q.size()));
        chk("jump", 64'(mif.jump), 64'(h.jump & v));
        chk("memtoreg", 64'(mif.memtoreg), 64'(h.memtoreg & v));
        rw_exp = h.regwrite & v & (h.regDstMux != 0);
        chk("regwrite_zrs1", 64'(mif.regwrite), 64'(rw_exp));
        chk("regwrite_zrs0", 64'(mif0.regwrite), 64'(h.regwrite & v));
        chk("aluResult", 64'(mif.aluResult), 64'(h.aluResult));
        chk("memReadData", 64'(mif.memReadData), 64'(h.memReadData));
        chk("regDstMux", 64'(mif.regDstMux), 64'(h.regDstMux));
        chk("wbData", 64'(mif.wbData), 64'(h.memtoreg ? h.memReadData : h.aluResult));
        chk("occupancy_zrs0", 64'(mif0.occupancy), 64'(q.size()));
        chk("wbData_zrs0", 64'(mif0.wbData), 64'(h.memtoreg ? h.memReadData : h.aluResult));
    endtask

    task automatic drive(input logic v, input logic rw, input logic j, input logic m,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] dst, input logic ordy, input logic fl);
        mif.in_valid      = v;
        mif.regwriteIn    = rw;
        mif.jumpIn        = j;
        mif.memtoregIn    = m;
        mif.aluResultIn   = alu;
        mif.memReadDataIn = mem;
        mif.regDstMuxIn   = dst;
        mif.out_ready     = ordy;
        mif.flush         = fl;
    endtask

    // One clock: model treats the stage as a 2-deep in-order FIFO.
    task automatic step();
        bit push;
        bit pop;
        wb_payload_t p;
        push = mif.in_valid && (q.size() < 2);
        pop  = (q.size() > 0) && mif.out_ready;
        p = '{regwrite: mif.regwriteIn, jump: mif.jumpIn, memtoreg: mif.memtoregIn,
              aluResult: mif.aluResultIn, memReadData: mif.memReadDataIn,
              regDstMux: mif.regDstMuxIn};
        @(posedge clk);
        #1;
        if (mif.flush) begin
            q.delete();
            stale = '0;
        end else begin
            if (q.size() > 0) stale = q[0];
            if (pop) void'(q.pop_front());
            if (push) q.push_back(p);
        end
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        stale = '0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset and flow-through
        startin = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_in_ready", 64'(mif.in_ready), 64'd1);
        startin = 1'b1;
        drive(1, 1, 0, 1, 40, 40, 17, 1, 0);
        step();
        chk("ft_valid", 64'(mif.out_valid), 64'd1);
        chk("ft_wb", 64'(mif.wbData), 64'd40);
        chk("ft_dst", 64'(mif.regDstMux), 64'd17);
        chk("ft_rw", 64'(mif.regwrite), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        chk("ft_drain_valid", 64'(mif.out_valid), 64'd0);
        chk("ft_drain_rw", 64'(mif.regwrite), 64'd0);

        // Backpressure fill
        drive(1, 1, 0, 0, 1, 100, 3, 0, 0);
        step();
        drive(1, 1, 1, 0, 2, 200, 4, 0, 0);
        step();
        chk("bp_occ", 64'(mif.occupancy), 64'd2);
        chk("bp_in_ready", 64'(mif.in_ready), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_alu", 64'(mif.aluResult), 64'd1);
        end
        mif.out_ready = 1'b1;
        step();
        chk("bp_pop1_alu", 64'(mif.aluResult), 64'd2);
        chk("bp_pop1_occ", 64'(mif.occupancy), 64'd1);
        chk("bp_pop1_rdy", 64'(mif.in_ready), 64'd1);
        step();
        chk("bp_pop2_occ", 64'(mif.occupancy), 64'd0);

        // Simultaneous push/pop at occupancy 1
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 32'(10 + i), 0, 5, 1, 0);
            step();
            chk("stream_alu", 64'(mif.aluResult), 64'(10 + i));
            chk("stream_occ", 64'(mif.occupancy), 64'd1);
            chk("stream_rdy", 64'(mif.in_ready), 64'd1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();

        // Flush beats push
        drive(1, 1, 0, 0, 21, 0, 6, 0, 0);
        step();
        drive(1, 1, 0, 0, 22, 0, 7, 0, 0);
        step();
        drive(1, 1, 1, 1, 99, 99, 9, 0, 1);
        step();
        chk("flush_occ", 64'(mif.occupancy), 64'd0);
        chk("flush_valid", 64'(mif.out_valid), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        chk("flush_no99", 64'(mif.aluResult == 32'd99), 64'd0);

        // r0 suppression
        drive(1, 1, 0, 0, 55, 0, 0, 0, 0);
        step();
        chk("r0_zrs1", 64'(mif.regwrite), 64'd0);
        chk("r0_zrs0", 64'(mif0.regwrite), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();

        // Async reset mid-stream
        drive(1, 0, 0, 0, 31, 0, 8, 0, 0);
        step();
        drive(1, 0, 0, 0, 32, 0, 8, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        startin = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("arst_occ", 64'(mif.occupancy), 64'd0);
        #2;
        startin = 1'b1;
        drive(1, 1, 0, 0, 7, 0, 12, 0, 0);
        step();
        chk("arst_alu7", 64'(mif.aluResult), 64'd7);
        chk("arst_occ1", 64'(mif.occupancy), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                  1'($urandom), $urandom_range(0, 31) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
- Parametrised next-generation MEM/WB pipeline register between the data-memory stage and register-file writeback.
- Adds a valid/ready handshake with a 2-entry skid buffer, so writeback can stall without a combinational ready path back into MEM.
- Adds synchronous flush, bubble-safe control outputs, optional r0 write suppression, and the writeback data mux.

Parameters:
- DATA_W, 32, width of aluResult, memReadData and wbData
- REG_W, 5, width of the destination register index
- ZERO_REG_SUPPRESS, 1, when 1, regwrite is forced to 0 if regDstMux == 0

Ports:
- clk  input  1  rising-edge clock
- startin  input  1  asynchronous active-low reset
- flush  input  1  synchronous; discards all held entries
- in_valid  input  1  MEM presents a valid entry
- in_ready  output  1  stage can accept an entry this cycle
- regwriteIn, jumpIn, memtoregIn  input  1 each  control bits from MEM
- aluResultIn  input  DATA_W  ALU result
- memReadDataIn  input  DATA_W  load data
- regDstMuxIn  input  REG_W  destination register index
- out_valid  output  1  head entry is valid
- out_ready  input  1  writeback consumes the head this cycle
- regwrite, jump, memtoreg  output  1 each  head control bits, gated by out_valid
- aluResult, memReadData  output  DATA_W  head payload
- regDstMux  output  REG_W  head destination index
- wbData  output  DATA_W  memtoreg ? memReadData : aluResult (from head payload)
- occupancy  output  2  held entries, range 0..2

Behaviour:
- Storage: head register (H) and skid register (S), each holding a valid bit and the full payload.
- Reset (startin=0, asynchronous):
  - H and S valid bits and payloads cleared to 0.
  - All outputs are 0 except in_ready, which is 1.
  - Reset dominates flush and push.
- Handshake signals:
  - in_ready = !S.valid. It is decoded only from flops, with no path from out_ready.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - out_valid = H.valid.
- Per-cycle update, applied in this priority order:
  - flush=1: H.valid and S.valid go to 0 and payloads are cleared. Any concurrent push is dropped. Next cycle occupancy=0 and in_ready=1.
  - H empty, push: entry loads into H. out_valid=1 next cycle (1-cycle latency).
  - H full, pop, S empty, push: new entry replaces H.
  - H full, pop, S empty, no push: H.valid goes to 0; payload holds stale data.
  - H full, no pop, push: entry loads into S. in_ready=0 next cycle.
  - H full, S full, pop: S moves to H and S.valid goes to 0. in_ready=1 next cycle. No push is possible this cycle.
  - H full, no pop, no push: all state held.
- Order is preserved: no entry is lost or duplicated, and S never holds an entry while H is empty.
- Output gating:
  - jump and memtoreg = H.bit & H.valid.
  - regwrite = H.regwrite & H.valid & !(ZERO_REG_SUPPRESS & (regDstMux == 0)).
  - Data outputs show H payload regardless of valid; writeback qualifies them with out_valid.
- wbData is combinational from H only; there is no bypass from the inputs.
- occupancy = H.valid + S.valid.
- Reset asserted mid-operation: state clears immediately. On release, the first push behaves as push into empty.

Decomposition:
- Shared package holds:
  - a payload struct typedef (regwrite, jump, memtoreg, aluResult, memReadData, regDstMux), parameterised by DATA_W/REG_W through package constants DATA_W_DEF=32 and REG_W_DEF=5;
  - the writeback-select encoding constants.
- One natural sub-module: skid_reg2, a generic 2-entry valid/ready skid buffer over an opaque payload vector. The top-level adds output gating and the wbData mux.

Test Plan:
- Reset/flow-through: startin=0 for 2 cycles → all outputs 0 and in_ready=1. Release, push {regwrite=1, memtoreg=1, alu=40, mem=40, dst=17} with out_ready=1 → next cycle out_valid=1, wbData=40, regDstMux=17, regwrite=1. Following cycle, with no push → out_valid=0 and regwrite=0.
- Backpressure fill: out_ready=0, push A (alu=1), then B (alu=2) → occupancy=2 and in_ready=0. Hold out_ready=0 for 3 cycles → aluResult stays 1. Raise out_ready=1 → alu 1 then 2 pop on consecutive cycles, occupancy goes 2→1→0, and in_ready returns to 1 after the first pop.
- Simultaneous push/pop at occupancy 1: stream alu=10,11,12 with out_ready=1 continuously → one output per cycle in order, occupancy stays at 1, in_ready stays at 1.
- Flush priority: occupancy=2, assert flush with in_valid=1 (alu=99) → next cycle occupancy=0, out_valid=0, and 99 never appears.
- r0 suppression: push {regwrite=1, dst=0} → regwrite=0. Repeat with ZERO_REG_SUPPRESS=0 → regwrite=1.
- Async reset mid-stream: occupancy=2, drop startin between clock edges → outputs clear before the next edge. After release, push alu=7 → it appears alone with occupancy=1.
